ram_stim_gen: RTL
=================

Name: ram_stim_gen

Overview:
- Sequential stimulus generator and initiator for the RAM verification path.
- On a start pulse it writes a Gray-coded data pattern into every RAM address, then reads every address back.
- For each read it publishes the expected Gray word one cycle after the read request.
- It samples the RAM checker's pass/fail flag on each expected-data cycle, counts mismatches, and signals completion.

Parameters:
- DATA_SIZE, 4, width of RAM data words and of the Gray pattern.
- ADDR_SIZE, 3, RAM address width; DEPTH = 2^ADDR_SIZE words are exercised.
- ERR_W, 8, width of the saturating mismatch counter.

Ports:
- clk  input  1  single system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to run a write/read pass; ignored while busy=1.
- seed  input  DATA_SIZE  pattern offset, latched on accepted start.
- check_ok  input  1  checker result (1 = conductual and structural outputs match).
- wr_en  output  1  RAM write strobe.
- wr_addr  output  ADDR_SIZE  RAM write address.
- data_in  output  DATA_SIZE  RAM write data, Gray-coded.
- rd_en  output  1  RAM read strobe.
- rd_addr  output  ADDR_SIZE  RAM read address.
- exp_data  output  DATA_SIZE  expected read data for the checker.
- exp_valid  output  1  exp_data valid; check_ok sampled this cycle.
- busy  output  1  pass in progress.
- done  output  1  pass complete; held until next accepted start or reset.
- err_count  output  ERR_W  mismatches in last/current pass, saturating.

Behaviour:
- Clock and reset: clk is the single clock; reset is synchronous and active-high.
- Reset: all outputs are registered and go to 0 on the first edge with reset=1; the FSM enters IDLE.
  - Reset mid-pass aborts immediately; no further writes or reads are issued.
- Pattern: word for address a = G(seed + a). Sum truncated to DATA_SIZE bits (mod 2^DATA_SIZE); G(x) = x ^ (x >> 1).
- FSM states: IDLE, WRITE, READ, DRAIN, DONE.
  - IDLE: all strobes 0. start=1 at edge k → WRITE; seed latched; err_count cleared; done cleared; busy=1.
  - WRITE: wr_en=1 for DEPTH consecutive cycles after edges k .. k+DEPTH-1.
    - wr_addr = 0, 1, …, DEPTH-1; data_in = G(seed + wr_addr).
    - After the last write → READ with no idle gap.
  - READ: rd_en=1 for DEPTH cycles, rd_addr = 0 … DEPTH-1; wr_en=0, data_in=0.
    - After the last read → DRAIN.
  - DRAIN: one cycle; rd_en=0. The final exp_valid is still high this cycle.
  - DONE: busy=0, done=1. A new start → WRITE (same as IDLE).
- Expected data:
  - exp_valid rises one cycle after each rd_en cycle; exp_data = G(seed + address read the previous cycle). RAM read latency is fixed at 1.
  - exp_data is held at its last value when exp_valid=0.
- Error counting:
  - On each edge where exp_valid=1 and check_ok=0, err_count increments.
  - err_count saturates at 2^ERR_W-1; it never wraps.
  - check_ok is ignored when exp_valid=0.
- Timing:
  - done=1 first appears 2·DEPTH+1 cycles after the start edge.
  - busy is high for exactly 2·DEPTH+1 cycles.
- Boundaries:
  - start while busy: ignored; seed not re-latched.
  - start and reset in the same cycle: reset wins.
  - wr_addr and rd_addr never wrap within a pass.
  - seed+a overflow wraps mod 2^DATA_SIZE.
  - wr_en and rd_en are never both 1.

Test Plan:
1. reset=1 for 2 cycles, then start=1 for 1 cycle with seed=0, check_ok held 1 → data_in = 0,1,3,2,6,7,5,4 at wr_addr 0–7; exp_data the same sequence at exp_valid cycles; done=1 at cycle 17 after start; err_count=0.
2. seed=14 → data_in at addr 0..3 = 9,8,0,1 (wrap of seed+a); the exp_data sequence matches.
3. check_ok forced 0 on the 3rd and 6th exp_valid cycles, plus one pulse of 0 when exp_valid=0 → err_count=2.
4. ERR_W=2, check_ok=0 throughout → err_count saturates at 3, not 0.
5. start pulsed again during READ → ignored; pass ends on the original schedule. A start after done → new pass, err_count cleared.
6. reset asserted in the 5th WRITE cycle → all outputs 0 next edge, FSM IDLE; no rd_en ever observed until a new start.

Source files
------------

// File: rtl/ram_stim_gen_if.sv
// rtl/ram_stim_gen_if.sv - stimulus generator bus: control, RAM strobes, expected data, status.
interface ram_stim_gen_if #(
   parameter int DATA_SIZE = 4,
   parameter int ADDR_SIZE = 3,
   parameter int ERR_W     = 8
);
   logic                 start;
   logic [DATA_SIZE-1:0] seed;
   logic                 check_ok;
   logic                 wr_en;
   logic [ADDR_SIZE-1:0] wr_addr;
   logic [DATA_SIZE-1:0] data_in;
   logic                 rd_en;
   logic [ADDR_SIZE-1:0] rd_addr;
   logic [DATA_SIZE-1:0] exp_data;
   logic                 exp_valid;
   logic                 busy;
   logic                 done;
   logic [ERR_W-1:0]     err_count;

   modport master (
      input  start, seed, check_ok,
      output wr_en, wr_addr, data_in, rd_en, rd_addr,
             exp_data, exp_valid, busy, done, err_count
   );

   modport slave (
      output start, seed, check_ok,
      input  wr_en, wr_addr, data_in, rd_en, rd_addr,
             exp_data, exp_valid, busy, done, err_count
   );
endinterface

// File: rtl/ram_stim_gen.sv
// rtl/ram_stim_gen.sv - writes a Gray pattern to every RAM word, reads it back, counts checker mismatches.
module ram_stim_gen #(
   parameter int DATA_SIZE = 4,
   parameter int ADDR_SIZE = 3,
   parameter int ERR_W     = 8
) (
   input  logic           clk,
   input  logic           reset,
   ram_stim_gen_if.master bus
);
   typedef enum logic [2:0] {ST_IDLE, ST_WRITE, ST_READ, ST_DRAIN, ST_DONE} state_t;

   state_t               state, state_nxt;
   logic [ADDR_SIZE-1:0] cnt, cnt_nxt;
   logic [DATA_SIZE-1:0] seed_q, seed_nxt;

   logic                 wr_en_q, wr_en_nxt;
   logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_nxt;
   logic [DATA_SIZE-1:0] data_in_q, data_in_nxt;
   logic                 rd_en_q, rd_en_nxt;
   logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_nxt;
   logic [DATA_SIZE-1:0] exp_data_q, exp_data_nxt;
   logic                 exp_valid_q, exp_valid_nxt;
   logic                 busy_q, busy_nxt;
   logic                 done_q, done_nxt;
   logic [ERR_W-1:0]     err_q, err_nxt;
   logic                 accept;

   function automatic logic [DATA_SIZE-1:0] gray(input logic [DATA_SIZE-1:0] x);
      return x ^ (x >> 1);
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         seed_q <= '0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         seed_q <= seed_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      seed_nxt  = seed_q;
      accept    = 1'b0;
      case (state)
         ST_IDLE, ST_DONE: begin
            if (bus.start) begin
               accept    = 1'b1;
               state_nxt = ST_WRITE;
               cnt_nxt   = '0;
               seed_nxt  = bus.seed;
            end
         end
         ST_WRITE: begin
            if (cnt == '1) begin
               state_nxt = ST_READ;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         ST_READ: begin
            if (cnt == '1) begin
               state_nxt = ST_DRAIN;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         ST_DRAIN: state_nxt = ST_DONE;
         default:  state_nxt = ST_IDLE;
      endcase

      // Outputs are registered from the next state so they line up with the phase they describe.
      wr_en_nxt     = (state_nxt == ST_WRITE);
      wr_addr_nxt   = wr_en_nxt ? cnt_nxt : '0;
      data_in_nxt   = wr_en_nxt ? gray(seed_nxt + DATA_SIZE'(cnt_nxt)) : '0;
      rd_en_nxt     = (state_nxt == ST_READ);
      rd_addr_nxt   = rd_en_nxt ? cnt_nxt : '0;
      exp_valid_nxt = rd_en_q;
      exp_data_nxt  = rd_en_q ? gray(seed_q + DATA_SIZE'(rd_addr_q)) : exp_data_q;
      busy_nxt      = (state_nxt == ST_WRITE) || (state_nxt == ST_READ) || (state_nxt == ST_DRAIN);
      done_nxt      = (state_nxt == ST_DONE);

      err_nxt = err_q;
      if (accept) begin
         err_nxt = '0;
      end else if (exp_valid_q && !bus.check_ok && (err_q != {ERR_W{1'b1}})) begin
         err_nxt = err_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         data_in_q   <= '0;
         rd_en_q     <= 1'b0;
         rd_addr_q   <= '0;
         exp_data_q  <= '0;
         exp_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= '0;
      end else begin
         wr_en_q     <= wr_en_nxt;
         wr_addr_q   <= wr_addr_nxt;
         data_in_q   <= data_in_nxt;
         rd_en_q     <= rd_en_nxt;
         rd_addr_q   <= rd_addr_nxt;
         exp_data_q  <= exp_data_nxt;
         exp_valid_q <= exp_valid_nxt;
         busy_q      <= busy_nxt;
         done_q      <= done_nxt;
         err_q       <= err_nxt;
      end
   end

   assign bus.wr_en     = wr_en_q;
   assign bus.wr_addr   = wr_addr_q;
   assign bus.data_in   = data_in_q;
   assign bus.rd_en     = rd_en_q;
   assign bus.rd_addr   = rd_addr_q;
   assign bus.exp_data  = exp_data_q;
   assign bus.exp_valid = exp_valid_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.err_count = err_q;
endmodule
